axi_video_scan: RTL

Framebuffer scan-out stage downstream of the SD-card picture loader. Once the loader has written a full frame of 32-bit-per-pixel words (0x00RRGGBB, row-major, row 0 = top) at the target base address, this block reads the frame back over AXI4 INCR bursts. It buffers the pixels in an internal FIFO and emits them as an AXI4-Stream video stream with start-of-frame (tuser) and end-of-line (tlast) markers for the video output pipeline.

---
 rtl/axi_video_scan_if.sv | 41 ++++
 rtl/axi_video_scan.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/axi_video_scan_if.sv
// axi_video_scan_if: AXI4 read channels plus the AXI4-Stream video output of the scan-out block.
// Latency: none, wires only.
// Backpressure: carried by the arready/rready/tready handshakes between the modports.
interface axi_video_scan_if;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arqos;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [23:0] m_axis_video_tdata;
  logic        m_axis_video_tvalid;
  logic        m_axis_video_tready;
  logic        m_axis_video_tuser;
  logic        m_axis_video_tlast;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
           m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid, m_axi_rready,
           m_axis_video_tdata, m_axis_video_tvalid, m_axis_video_tuser, m_axis_video_tlast,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
           m_axis_video_tready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
           m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid, m_axi_rready,
           m_axis_video_tdata, m_axis_video_tvalid, m_axis_video_tuser, m_axis_video_tlast,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
           m_axis_video_tready
  );
endinterface

// File: rtl/axi_video_scan.sv
// axi_video_scan: reads a framebuffer back over AXI4 INCR bursts and emits it as AXI4-Stream video.
// Latency: an R beat accepted at edge N appears on tdata/tvalid at N+1 when the pixel FIFO was empty.
// Backpressure: an AR is issued only with room for a full burst, so tready may stall forever losslessly.
// Optional: define AXI_VIDEO_SCAN_LOOP_EN to rescan frames continuously after one scan_start.
module axi_video_scan #(
  parameter logic [31:0] C_M_AXI_TARGET_SLAVE_BASE_ADDR = 32'h40000000,
  parameter int          H_ACTIVE   = 1920,
  parameter int          V_ACTIVE   = 1080,
  parameter int          BURST_LEN  = 16,
  parameter int          FIFO_DEPTH = 64
) (
  input  logic             m_axi_aclk,
  input  logic             m_axi_aresetn,
  axi_video_scan_if.master bus,
  input  logic             scan_start,
  output logic             scan_busy,
  output logic             scan_done,
  output logic             scan_error
);
  localparam int NUM_BURSTS = (H_ACTIVE * V_ACTIVE) / BURST_LEN;
  localparam int BCW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW  = AW + 1;
  localparam logic [BCW-1:0] BURST_LAST = BCW'(NUM_BURSTS - 1);
  localparam logic [PW-1:0]  DEPTH_P    = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0]  BURST_P    = PW'(BURST_LEN);
  localparam logic [31:0]    ADDR_INC   = 32'(BURST_LEN * 4);
  localparam logic [15:0]    X_LAST     = 16'(H_ACTIVE - 1);
  localparam logic [15:0]    Y_LAST     = 16'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [31:0]     offset_q, offset_d;
  logic [BCW-1:0]  burst_q, burst_d;
  logic            arvalid_q, arvalid_d;
  logic            error_q, error_d;
  logic            done_q, done_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]     x_q, x_d, y_q, y_d;
  logic [23:0]     fifo_mem_q [FIFO_DEPTH];

  logic [PW-1:0]   occ, free;
  logic            fifo_vld, push, pop, final_pop;
  logic            unused_rdata_hi;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign occ       = wr_ptr_q - rd_ptr_q;
  assign free      = DEPTH_P - occ;
  assign fifo_vld  = (occ != '0);
  assign push      = bus.m_axi_rvalid & bus.m_axi_rready;
  assign pop       = fifo_vld & bus.m_axis_video_tready;
  assign final_pop = pop & (x_q == X_LAST) & (y_q == Y_LAST);
  assign unused_rdata_hi = ^bus.m_axi_rdata[31:24];

  assign bus.m_axi_araddr  = C_M_AXI_TARGET_SLAVE_BASE_ADDR + offset_q;
  assign bus.m_axi_arlen   = 8'(BURST_LEN - 1);
  assign bus.m_axi_arsize  = 3'h2;
  assign bus.m_axi_arburst = 2'h1;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'h2;
  assign bus.m_axi_arprot  = 3'h0;
  assign bus.m_axi_arqos   = 4'h0;
  assign bus.m_axi_arvalid = arvalid_q;
  // Space for the whole burst was reserved before the AR, so R is never stalled.
  assign bus.m_axi_rready  = (state_q == DATA);

  assign bus.m_axis_video_tvalid = fifo_vld;
  assign bus.m_axis_video_tdata  = fifo_vld ? fifo_mem_q[rd_ptr_q[AW-1:0]] : 24'h0;
  assign bus.m_axis_video_tuser  = fifo_vld & (x_q == 16'd0) & (y_q == 16'd0);
  assign bus.m_axis_video_tlast  = fifo_vld & (x_q == X_LAST);

  assign scan_busy  = (state_q != IDLE);
  assign scan_done  = done_q;
  assign scan_error = error_q;

  // Next-state logic for the scan FSM, the pixel FIFO pointers and the raster position.
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    burst_d   = burst_q;
    arvalid_d = arvalid_q;
    error_d   = error_q;
    done_d    = 1'b0;
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    x_d       = x_q;
    y_d       = y_q;

    case (state_q)
      IDLE: begin
        if (scan_start) begin
          offset_d = 32'd0;
          burst_d  = '0;
          error_d  = 1'b0;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        // Free space only grows while here, so a raised arvalid never loses its reservation.
        if (arvalid_q) begin
          if (bus.m_axi_arready) begin
            arvalid_d = 1'b0;
            offset_d  = offset_q + ADDR_INC;
            state_d   = DATA;
          end
        end else if (free >= BURST_P) begin
          arvalid_d = 1'b1;
        end
      end
      DATA: begin
        if (push && bus.m_axi_rlast) begin
          if (burst_q == BURST_LAST) begin
            state_d = DRAIN;
          end else begin
            burst_d = burst_q + 1'b1;
            state_d = ADDR;
          end
        end
      end
      DRAIN: begin
        if (final_pop) begin
          done_d = 1'b1;
`ifdef AXI_VIDEO_SCAN_LOOP_EN
          offset_d = 32'd0;
          burst_d  = '0;
          state_d  = ADDR;
`else
          state_d  = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // A bad response is flagged but the beat is still streamed.
    if (push && (bus.m_axi_rresp != 2'b00)) error_d = 1'b1;

    if (pop) begin
      if (x_q == X_LAST) begin
        x_d = 16'd0;
        y_d = (y_q == Y_LAST) ? 16'd0 : y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  // State registers with synchronous active-low reset; reset also flushes the FIFO.
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state_q   <= IDLE;
      offset_q  <= 32'd0;
      burst_q   <= '0;
      arvalid_q <= 1'b0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      x_q       <= 16'd0;
      y_q       <= 16'd0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      burst_q   <= burst_d;
      arvalid_q <= arvalid_d;
      error_q   <= error_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  // Pixel storage; contents need no reset because tvalid is derived from the pointers.
  always_ff @(posedge m_axi_aclk) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= bus.m_axi_rdata[23:0];
  end
endmodule
